veri_lockstep_checker: RTL and testbench
========================================

Name: veri_lockstep_checker

Overview:
- Parametrised lockstep checker that pairs a superscalar OOO core with the single-issue ISA reference model.
- Each cycle, the OOO core may retire 0..COMMIT_W instructions. The checker records a snapshot of the core's architectural state for every cycle that has at least one commit.
- It then steps the ISA model one instruction per cycle until the model has caught up to a snapshot, and compares pc_last and the register file at that point.
- It also checks that initial states match, flags snapshot-queue overflow, and provides a parametrised liveness monitor.

Parameters:
- COMMIT_W, 2, maximum OOO commits per cycle.
- PC_W, 4, width of pc_last.
- RF_SIZE, 4, number of architectural registers.
- DATA_W, 4, register width.
- FIFO_DEPTH, 4, snapshot queue depth (power of 2, >=2).
- LIVE_LIMIT, 10, number of consecutive zero-commit cycles tolerated.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- init_match  in  1  harness-computed equality of OOO/ISA rf, memi and memd initial state.
- impl_commit_cnt  in  $clog2(COMMIT_W+1)  instructions retired by OOO this cycle.
- impl_pc_last  in  PC_W  OOO pc of last retired instruction.
- impl_rf  in  RF_SIZE*DATA_W  OOO architectural rf, flattened, entry p at [p*DATA_W +: DATA_W].
- isa_step  out  1  ISA clock enable; ISA advances one instruction on each posedge with isa_step=1.
- isa_pc_last  in  PC_W  ISA pc_last.
- isa_rf  in  RF_SIZE*DATA_W  ISA rf, flattened, same layout as impl_rf.
- mismatch_rf  out  RF_SIZE  sticky per-register mismatch flags.
- mismatch_pc  out  1  sticky pc mismatch flag.
- init_fail  out  1  sticky flag: initial state differed.
- overflow  out  1  sticky flag: a snapshot was dropped.
- proto_err  out  1  sticky flag: impl_commit_cnt > COMMIT_W.
- pending  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.
- live  out  1  high while idle_cnt < LIVE_LIMIT.
- correct  out  1  equals ~(|mismatch_rf | mismatch_pc | init_fail | overflow | proto_err).

Behaviour:
- Reset (rst=0, asynchronous):
  - All sticky flags are 0, the queue is empty, state is IDLE, isa_step=0, idle_cnt=0.
  - init_chk=1 (internal flag; live=1 follows).
- init_chk:
  - Stays 1 for the first clk edge after rst deasserts.
  - At that edge, init_match=0 sets init_fail. init_chk then clears.
- Push:
  - Occurs on a cycle with 1 <= impl_commit_cnt <= COMMIT_W.
  - The pushed entry is {cnt, impl_pc_last, impl_rf}.
- Queue full:
  - If the queue is full and no pop happens in the same cycle, the entry is dropped and overflow is set.
  - If a pop happens in the same cycle, both the push and the pop take effect and occupancy is unchanged.
- impl_commit_cnt > COMMIT_W: proto_err is set and nothing is pushed.
- impl_commit_cnt = 0: nothing is pushed.
- Step FSM, state held in flops; isa_step is a registered output equal to (state==STEP):
  - IDLE: if the queue is non-empty, load step_rem <= head.cnt and go to STEP. Otherwise stay in IDLE.
  - STEP: isa_step=1 each cycle and step_rem decrements. When step_rem==1, go to CHECK.
  - CHECK: isa_step=0, so the ISA outputs now reflect all head.cnt instructions.
    - Compare isa_pc_last against head.pc; a difference sets mismatch_pc.
    - Compare isa_rf[p] against head.rf[p] for each p; a difference sets mismatch_rf[p].
    - Pop the head. If another entry remains, load step_rem and go straight to STEP; otherwise go to IDLE.
- Throughput: an entry with cnt=k is retired k+1 cycles after it reaches the head.
- Sticky flags: once set, a flag clears only on reset. Comparison continues after a mismatch.
- idle_cnt:
  - Counts consecutive cycles with impl_commit_cnt==0 and saturates at LIVE_LIMIT.
  - Clears on any cycle with nonzero impl_commit_cnt.
- Async reset mid-operation: the whole queue and FSM are discarded immediately and isa_step drops in the same instant. The ISA model is reset by the harness from the same rst.
- Pointers: the queue uses wrap-around pointers with an extra MSB for full/empty detection. pending = wptr - rptr.

Test Plan:
- Reset, then init_match=1 and 3 cycles of single commits with the OOO and ISA identical → isa_step pulses 3 times; correct=1; pending returns to 0 and state returns to IDLE.
- A commit cnt=2 with pc=4'h6 and ISA equal after 2 steps → isa_step is high for exactly 2 cycles, followed by CHECK; no flags set.
- ISA rf[2] differs by 1 at a check → mismatch_rf=4'b0100 and correct=0. The flag stays set through later matching checks until rst=0.
- 6 back-to-back cnt=2 commits with FIFO_DEPTH=4 → overflow=1 and pending saturates at 4. The surviving entries are still checked in order.
- init_match=0 on the first cycle after reset → init_fail=1. Also drive impl_commit_cnt=3 with COMMIT_W=2 → proto_err=1 and nothing is pushed.
- 10 consecutive zero-commit cycles → live=0 on the 10th; one commit → live=1 the next cycle. Asserting rst=0 while in STEP → isa_step=0 immediately and pending=0.

Source files
------------

// File: rtl/veri_lockstep_checker.sv
// rtl/veri_lockstep_checker.sv - lockstep checker pairing a superscalar OOO core with a single-issue ISA model
module veri_lockstep_checker #(
    parameter int COMMIT_W   = 2,
    parameter int PC_W       = 4,
    parameter int RF_SIZE    = 4,
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int LIVE_LIMIT = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          init_match,
    input  logic [$clog2(COMMIT_W+1)-1:0] impl_commit_cnt,
    input  logic [PC_W-1:0]               impl_pc_last,
    input  logic [RF_SIZE*DATA_W-1:0]     impl_rf,
    output logic                          isa_step,
    input  logic [PC_W-1:0]               isa_pc_last,
    input  logic [RF_SIZE*DATA_W-1:0]     isa_rf,
    output logic [RF_SIZE-1:0]            mismatch_rf,
    output logic                          mismatch_pc,
    output logic                          init_fail,
    output logic                          overflow,
    output logic                          proto_err,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic                          live,
    output logic                          correct
);
    localparam int CNT_W = $clog2(COMMIT_W + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;
    localparam int IW    = $clog2(LIVE_LIMIT + 1);
    localparam int RFW   = RF_SIZE * DATA_W;

    typedef enum logic [1:0] {IDLE, STEP, CHECK} state_t;

    state_t            state;
    logic [CNT_W-1:0]  step_rem;
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [PW-1:0]     rptr_nxt;
    logic [PW-1:0]     occ;
    logic [AW-1:0]     head;
    logic [AW-1:0]     head_nxt;
    logic              init_chk;
    logic [IW-1:0]     idle_cnt;

    logic [CNT_W-1:0]  q_cnt [FIFO_DEPTH];
    logic [PC_W-1:0]   q_pc  [FIFO_DEPTH];
    logic [RFW-1:0]    q_rf  [FIFO_DEPTH];

    logic              cnt_ok;
    logic              cnt_bad;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;
    logic              pc_diff;
    logic [RF_SIZE-1:0] rf_diff;

    assign occ      = wptr - rptr;
    assign rptr_nxt = rptr + 1'b1;
    assign head     = rptr[AW-1:0];
    assign head_nxt = rptr_nxt[AW-1:0];
    assign full     = (occ == PW'(FIFO_DEPTH));
    assign cnt_bad  = (impl_commit_cnt > CNT_W'(COMMIT_W));
    assign cnt_ok   = (impl_commit_cnt != '0) && !cnt_bad;
    assign pop      = (state == CHECK);
    // A full queue still accepts a push when the head retires in the same cycle.
    assign push     = cnt_ok && (!full || pop);
    assign drop     = cnt_ok && full && !pop;
    assign pc_diff  = (isa_pc_last != q_pc[head]);

    always_comb begin
        rf_diff = '0;
        for (int p = 0; p < RF_SIZE; p++)
            rf_diff[p] = (isa_rf[p*DATA_W +: DATA_W] != q_rf[head][p*DATA_W +: DATA_W]);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_cnt[wptr[AW-1:0]] <= impl_commit_cnt;
            q_pc[wptr[AW-1:0]]  <= impl_pc_last;
            q_rf[wptr[AW-1:0]]  <= impl_rf;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            isa_step    <= 1'b0;
            step_rem    <= '0;
            wptr        <= '0;
            rptr        <= '0;
            mismatch_rf <= '0;
            mismatch_pc <= 1'b0;
            init_fail   <= 1'b0;
            overflow    <= 1'b0;
            proto_err   <= 1'b0;
            init_chk    <= 1'b1;
            idle_cnt    <= '0;
        end else begin
            init_chk <= 1'b0;
            if (init_chk && !init_match)
                init_fail <= 1'b1;
            if (cnt_bad)
                proto_err <= 1'b1;
            if (drop)
                overflow <= 1'b1;
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr_nxt;

            if (impl_commit_cnt != '0)
                idle_cnt <= '0;
            else if (idle_cnt != IW'(LIVE_LIMIT))
                idle_cnt <= idle_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (occ != '0) begin
                        step_rem <= q_cnt[head];
                        state    <= STEP;
                        isa_step <= 1'b1;
                    end
                end
                STEP: begin
                    step_rem <= step_rem - 1'b1;
                    if (step_rem == CNT_W'(1)) begin
                        state    <= CHECK;
                        isa_step <= 1'b0;
                    end
                end
                CHECK: begin
                    mismatch_pc <= mismatch_pc | pc_diff;
                    mismatch_rf <= mismatch_rf | rf_diff;
                    // Chain straight into the next snapshot to keep k+1 cycles per entry.
                    if (occ > PW'(1)) begin
                        step_rem <= q_cnt[head_nxt];
                        state    <= STEP;
                        isa_step <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        isa_step <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    isa_step <= 1'b0;
                end
            endcase
        end
    end

    assign pending = occ;
    assign live    = (idle_cnt < IW'(LIVE_LIMIT));
    assign correct = ~(|mismatch_rf | mismatch_pc | init_fail | overflow | proto_err);

endmodule

// File: tb/tb_veri_lockstep_checker.sv
// tb/tb_veri_lockstep_checker.sv - randomized and directed bench for veri_lockstep_checker
module tb_veri_lockstep_checker;
    localparam int COMMIT_W   = 2;
    localparam int PC_W       = 4;
    localparam int RF_SIZE    = 4;
    localparam int DATA_W     = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int LIVE_LIMIT = 10;
    localparam int CNT_W      = $clog2(COMMIT_W + 1);
    localparam int PEND_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int RFW        = RF_SIZE * DATA_W;
    localparam int NPROG      = 128;
    localparam int LOGN       = 8192;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              init_match = 1'b1;
    logic [CNT_W-1:0]  impl_commit_cnt = '0;
    logic [PC_W-1:0]   impl_pc_last = '0;
    logic [RFW-1:0]    impl_rf = '0;
    logic              isa_step;
    logic [PC_W-1:0]   isa_pc_last;
    logic [RFW-1:0]    isa_rf;
    logic [RF_SIZE-1:0] mismatch_rf;
    logic              mismatch_pc;
    logic              init_fail;
    logic              overflow;
    logic              proto_err;
    logic [PEND_W-1:0] pending;
    logic              live;
    logic              correct;

    veri_lockstep_checker #(
        .COMMIT_W(COMMIT_W), .PC_W(PC_W), .RF_SIZE(RF_SIZE),
        .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .LIVE_LIMIT(LIVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .init_match(init_match),
        .impl_commit_cnt(impl_commit_cnt), .impl_pc_last(impl_pc_last), .impl_rf(impl_rf),
        .isa_step(isa_step), .isa_pc_last(isa_pc_last), .isa_rf(isa_rf),
        .mismatch_rf(mismatch_rf), .mismatch_pc(mismatch_pc), .init_fail(init_fail),
        .overflow(overflow), .proto_err(proto_err), .pending(pending),
        .live(live), .correct(correct)
    );

    always #5 clk = ~clk;

    // Architectural program: state after i instructions, shared by both cores.
    logic [PC_W-1:0] prog_pc [NPROG];
    logic [RFW-1:0]  prog_rf [NPROG];
    int impl_idx  = 0;
    int isa_idx;
    int fault_idx = -1;
    int fault_reg = 0;
    logic fault_pc = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) isa_idx <= 0;
        else if (isa_step) isa_idx <= isa_idx + 1;
    end

    always_comb begin
        isa_pc_last = prog_pc[isa_idx % NPROG];
        isa_rf      = prog_rf[isa_idx % NPROG];
        if (isa_idx == fault_idx) begin
            if (fault_pc)
                isa_pc_last = isa_pc_last ^ PC_W'(1);
            else
                isa_rf[fault_reg*DATA_W +: DATA_W] = isa_rf[fault_reg*DATA_W +: DATA_W] + 1'b1;
        end
    end

    logic              step_log [LOGN];
    logic [PEND_W-1:0] pend_log [LOGN];
    int cyc = 0;

    always @(negedge clk) begin
        step_log[cyc % LOGN] = isa_step;
        pend_log[cyc % LOGN] = pending;
        cyc = cyc + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int k);
        @(posedge clk);
        #1;
        impl_commit_cnt = CNT_W'(k);
        if (k >= 1 && k <= COMMIT_W) impl_idx += k;
        impl_pc_last = prog_pc[impl_idx];
        impl_rf      = prog_rf[impl_idx];
    endtask

    task automatic do_reset(input logic im);
        @(posedge clk);
        #1;
        rst = 1'b0;
        impl_commit_cnt = '0;
        impl_idx = 0;
        fault_idx = -1;
        impl_pc_last = prog_pc[0];
        impl_rf = prog_rf[0];
        init_match = im;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic drain(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (pending == '0 && !isa_step) done = 1'b1;
        end
        check({tag, "_drain_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic scan(input int from, output int ns, output int mr, output int mp);
        int run;
        ns = 0; mr = 0; mp = 0; run = 0;
        for (int i = from; i < cyc; i++) begin
            if (step_log[i % LOGN]) begin
                ns++; run++;
                if (run > mr) mr = run;
            end else run = 0;
            if (int'(pend_log[i % LOGN]) > mp) mp = int'(pend_log[i % LOGN]);
        end
    endtask

    task automatic randomize_prog();
        for (int i = 0; i < NPROG; i++) begin
            prog_pc[i] = PC_W'($urandom);
            prog_rf[i] = RFW'($urandom);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, ns, mr, mp, k;
        int ends[$];
        logic hit, found;
        logic [RF_SIZE-1:0] exp_rf;

        randomize_prog();
        do_reset(1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_pending", 32'(pending), 0);
        check("rst_isa_step", 32'(isa_step), 0);
        check("rst_flags", {mismatch_rf, mismatch_pc, init_fail, overflow, proto_err}, 0);
        check("rst_live", 32'(live), 1);
        check("rst_correct", 32'(correct), 1);
        @(posedge clk);
        #1 rst = 1'b1;

        // three single commits, identical cores
        c0 = cyc;
        drive(1); drive(1); drive(1); drive(0);
        drain("single");
        scan(c0, ns, mr, mp);
        check("single_steps", ns, 3);
        check("single_correct", 32'(correct), 1);
        check("single_pending", 32'(pending), 0);
        check("single_isa_idx", isa_idx, impl_idx);

        // one cnt=2 commit ending at pc 6
        prog_pc[impl_idx + 2] = 4'h6;
        c0 = cyc;
        drive(2); drive(0);
        drain("dual");
        scan(c0, ns, mr, mp);
        check("dual_steps", ns, 2);
        check("dual_run", mr, 2);
        check("dual_flags", {mismatch_rf, mismatch_pc}, 0);
        check("dual_correct", 32'(correct), 1);

        // ISA rf[2] off by one at the next check, later checks clean
        fault_idx = impl_idx + 1;
        fault_reg = 2;
        fault_pc  = 1'b0;
        drive(1); drive(0);
        drain("rf2");
        check("rf2_mask", 32'(mismatch_rf), 32'b0100);
        check("rf2_correct", 32'(correct), 0);
        drive(2); drive(1); drive(0);
        drain("rf2_sticky");
        check("rf2_sticky", 32'(mismatch_rf), 32'b0100);
        check("rf2_pc", 32'(mismatch_pc), 0);
        do_reset(1'b1);
        @(negedge clk);
        check("rf2_cleared", 32'(mismatch_rf), 0);

        // six back-to-back cnt=2 commits overflow a depth-4 queue
        for (int i = 0; i < NPROG; i++) begin
            prog_pc[i] = 4'h3;
            prog_rf[i] = 16'h5a5a;
        end
        do_reset(1'b1);
        c0 = cyc;
        for (int i = 0; i < 6; i++) drive(2);
        drive(0);
        drain("ovf");
        scan(c0, ns, mr, mp);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_max_pending", mp, FIFO_DEPTH);
        check("ovf_isa_steps", isa_idx, 10);
        check("ovf_no_mismatch", {mismatch_rf, mismatch_pc}, 0);
        check("ovf_correct", 32'(correct), 0);

        // init mismatch and protocol error
        randomize_prog();
        do_reset(1'b0);
        @(posedge clk);
        @(negedge clk);
        init_match = 1'b1;
        check("init_fail", 32'(init_fail), 1);
        check("init_proto_clear", 32'(proto_err), 0);
        drive(3); drive(0);
        @(negedge clk);
        check("proto_err", 32'(proto_err), 1);
        check("proto_pending", 32'(pending), 0);
        check("proto_isa_step", 32'(isa_step), 0);

        // liveness
        do_reset(1'b1);
        @(negedge clk);
        for (int i = 1; i <= LIVE_LIMIT; i++) begin
            @(negedge clk);
            check($sformatf("live_%0d", i), 32'(live), 32'(i < LIVE_LIMIT));
        end
        drive(1);
        @(negedge clk);
        check("live_saturated", 32'(live), 0);
        drive(0);
        @(negedge clk);
        check("live_recover", 32'(live), 1);
        drain("live");

        // async reset while stepping
        drive(2); drive(0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (isa_step) found = 1'b1;
        end
        check("midstep_reached", 32'(found), 1);
        #1 rst = 1'b0;
        #1;
        check("midstep_isa_step", 32'(isa_step), 0);
        check("midstep_pending", 32'(pending), 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // randomized commit streams against a snapshot-set model
        for (int r = 0; r < 6; r++) begin
            randomize_prog();
            do_reset(1'b1);
            fault_idx = int'($urandom_range(1, 50));
            fault_pc  = 1'($urandom_range(0, 1));
            fault_reg = int'($urandom_range(0, RF_SIZE - 1));
            ends.delete();
            for (int g = 0; g < 30; g++) begin
                k = int'($urandom_range(0, COMMIT_W));
                drive(k);
                if (k > 0) ends.push_back(impl_idx);
                repeat (k + 1 + int'($urandom_range(0, 1))) drive(0);
            end
            drain($sformatf("rnd%0d", r));
            hit = 1'b0;
            foreach (ends[i]) if (ends[i] == fault_idx) hit = 1'b1;
            exp_rf = (hit && !fault_pc) ? RF_SIZE'(1 << fault_reg) : '0;
            check($sformatf("rnd%0d_rf", r), 32'(mismatch_rf), 32'(exp_rf));
            check($sformatf("rnd%0d_pc", r), 32'(mismatch_pc), 32'(hit && fault_pc));
            check($sformatf("rnd%0d_ovf", r), 32'(overflow), 0);
            check($sformatf("rnd%0d_steps", r), isa_idx, impl_idx);
            check($sformatf("rnd%0d_correct", r), 32'(correct), 32'(!hit));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
